// File: rtl/conv_operand_fetch.sv
// Operand sequencer for the convolution MAC: walks y, x, oc, ic, ky, kx over one column strip,
// fetches activation (strip memory, halo cache or zero pad) and weight, and streams them out.
module conv_operand_fetch #(
  parameter int DATA_WIDTH  = 16,
  parameter int FMAP_H      = 128,
  parameter int FMAP_W      = 1024,
  parameter int TILE_W      = 64,
  parameter int IN_CH       = 2,
  parameter int OUT_CH      = 16,
  parameter int KERNEL_SIZE = 3,
  localparam int HALO = KERNEL_SIZE / 2,
  localparam int ICB  = $clog2(IN_CH),
  localparam int OCB  = $clog2(OUT_CH),
  localparam int XW   = $clog2(FMAP_W),
  localparam int YW   = $clog2(FMAP_H),
  localparam int TW   = $clog2(TILE_W),
  localparam int KW   = $clog2(KERNEL_SIZE),
  localparam int HXW  = ($clog2(HALO) > 1) ? $clog2(HALO) : 1,
  localparam int ICW  = ICB + 1,
  localparam int OCW  = OCB + 1,
  localparam int IAW  = $clog2(IN_CH * FMAP_H * TILE_W),
  localparam int HAW  = ICB + 1 + YW + HXW,
  localparam int KAW  = ICB + 2 * KW + OCB
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  start,
  input  logic [ICW-1:0]        cfg_in_ch,
  input  logic [OCW-1:0]        cfg_out_ch,
  input  logic [XW-1:0]         cfg_x0,
  output logic                  running,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  in_re,
  output logic [IAW-1:0]        in_addr,
  input  logic [DATA_WIDTH-1:0] in_q,
  output logic                  halo_re,
  output logic [HAW-1:0]        halo_addr,
  input  logic [DATA_WIDTH-1:0] halo_q,
  output logic                  kern_re,
  output logic [KAW-1:0]        kern_addr,
  input  logic [DATA_WIDTH-1:0] kern_q,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic                  op_first,
  output logic                  op_last,
  output logic [XW-1:0]         op_x,
  output logic [YW-1:0]         op_y,
  output logic [OCB-1:0]        op_ch
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef enum logic [1:0] {SRC_ZERO, SRC_IN, SRC_HALO} src_t;

  state_t state;

  logic [KW-1:0]  cnt_kx, cnt_ky;
  logic [ICB-1:0] cnt_ic;
  logic [OCB-1:0] cnt_oc;
  logic [XW-1:0]  cnt_x;
  logic [YW-1:0]  cnt_y;
  logic [ICW-1:0] lat_in_ch;
  logic [OCW-1:0] lat_out_ch;
  logic [XW-1:0]  lat_x0, lat_x_end;

  logic           s1_v, s1_in_re, s1_halo_re, s1_first, s1_last;
  src_t           s1_src;
  logic [XW-1:0]  s1_x;
  logic [YW-1:0]  s1_y;
  logic [OCB-1:0] s1_oc;
  logic           s2_v, s2_first, s2_last;
  src_t           s2_src;
  logic [XW-1:0]  s2_x;
  logic [YW-1:0]  s2_y;
  logic [OCB-1:0] s2_oc;

  logic           idle, stall, legal, issue_en, tap_last, side;
  logic           kx_l, ky_l, ic_l, oc_l, x_l, y_l;
  logic [KW-1:0]  c_kx, c_ky, n_kx, n_ky;
  logic [ICB-1:0] c_ic, n_ic;
  logic [OCB-1:0] c_oc, n_oc;
  logic [XW-1:0]  c_x, n_x, c_x0, c_x_end, x_end_cfg;
  logic [YW-1:0]  c_y, n_y;
  logic [ICW-1:0] c_in_ch;
  logic [OCW-1:0] c_out_ch;
  logic [31:0]    strip_end;
  logic signed [31:0] yi, xi, x0s, hx;
  src_t           src;
  logic [IAW-1:0] ia;
  logic [HAW-1:0] ha;
  logic [KAW-1:0] ka;

  assign stall   = op_valid & ~op_ready;
  assign in_re   = s1_in_re & ~stall;
  assign halo_re = s1_halo_re & ~stall;
  assign kern_re = s1_v & ~stall;

  // In IDLE the issue stage sees the first tap of the incoming config so the
  // start edge itself issues tap 0; counters then hold the next tap to issue.
  always_comb begin
    idle      = (state == IDLE);
    strip_end = 32'(cfg_x0) + 32'(TILE_W);
    x_end_cfg = (strip_end > 32'(FMAP_W)) ? XW'(FMAP_W - 1) : XW'(strip_end - 32'd1);
    legal     = (cfg_in_ch != '0) && (cfg_in_ch <= ICW'(IN_CH)) &&
                (cfg_out_ch != '0) && (cfg_out_ch <= OCW'(OUT_CH));
    c_kx      = idle ? '0 : cnt_kx;
    c_ky      = idle ? '0 : cnt_ky;
    c_ic      = idle ? '0 : cnt_ic;
    c_oc      = idle ? '0 : cnt_oc;
    c_x       = idle ? cfg_x0 : cnt_x;
    c_y       = idle ? '0 : cnt_y;
    c_x0      = idle ? cfg_x0 : lat_x0;
    c_x_end   = idle ? x_end_cfg : lat_x_end;
    c_in_ch   = idle ? cfg_in_ch : lat_in_ch;
    c_out_ch  = idle ? cfg_out_ch : lat_out_ch;
    issue_en  = ~stall & ((state == RUN) | (idle & start & legal));

    kx_l = (c_kx == KW'(KERNEL_SIZE - 1));
    ky_l = (c_ky == KW'(KERNEL_SIZE - 1));
    ic_l = (ICW'(c_ic) == c_in_ch - ICW'(1));
    oc_l = (OCW'(c_oc) == c_out_ch - OCW'(1));
    x_l  = (c_x == c_x_end);
    y_l  = (c_y == YW'(FMAP_H - 1));
    tap_last = kx_l & ky_l & ic_l & oc_l & x_l & y_l;

    n_kx = kx_l ? '0 : c_kx + 1'b1;
    n_ky = kx_l ? (ky_l ? '0 : c_ky + 1'b1) : c_ky;
    n_ic = (kx_l & ky_l) ? (ic_l ? '0 : c_ic + 1'b1) : c_ic;
    n_oc = (kx_l & ky_l & ic_l) ? (oc_l ? '0 : c_oc + 1'b1) : c_oc;
    n_x  = (kx_l & ky_l & ic_l & oc_l) ? (x_l ? c_x0 : c_x + 1'b1) : c_x;
    n_y  = (kx_l & ky_l & ic_l & oc_l & x_l) ? c_y + 1'b1 : c_y;

    yi   = $signed(32'(c_y)) + $signed(32'(c_ky)) - HALO;
    xi   = $signed(32'(c_x)) + $signed(32'(c_kx)) - HALO;
    x0s  = $signed(32'(c_x0));
    src  = SRC_ZERO;
    side = 1'b0;
    hx   = '0;
    if (yi >= 0 && yi < FMAP_H && xi >= 0 && xi < FMAP_W) begin
      if (xi >= x0s && xi < x0s + TILE_W) begin
        src = SRC_IN;
      end else if (xi < x0s) begin
        src = SRC_HALO;
        hx  = xi - x0s + HALO;
      end else begin
        src  = SRC_HALO;
        side = 1'b1;
        hx   = xi - x0s - TILE_W;
      end
    end
    ia = {c_ic, YW'(yi), TW'(xi - x0s)};
    ha = {c_ic, side, YW'(yi), HXW'(hx)};
    ka = {c_ic, c_ky, c_kx, c_oc};
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state <= IDLE;
      running <= 1'b0; done <= 1'b0; cfg_err <= 1'b0;
      cnt_kx <= '0; cnt_ky <= '0; cnt_ic <= '0; cnt_oc <= '0; cnt_x <= '0; cnt_y <= '0;
      lat_in_ch <= '0; lat_out_ch <= '0; lat_x0 <= '0; lat_x_end <= '0;
      s1_v <= 1'b0; s1_in_re <= 1'b0; s1_halo_re <= 1'b0; s1_src <= SRC_ZERO;
      s1_first <= 1'b0; s1_last <= 1'b0; s1_x <= '0; s1_y <= '0; s1_oc <= '0;
      in_addr <= '0; halo_addr <= '0; kern_addr <= '0;
      s2_v <= 1'b0; s2_src <= SRC_ZERO; s2_first <= 1'b0; s2_last <= 1'b0;
      s2_x <= '0; s2_y <= '0; s2_oc <= '0;
      op_valid <= 1'b0; op_a <= '0; op_b <= '0; op_first <= 1'b0; op_last <= 1'b0;
      op_x <= '0; op_y <= '0; op_ch <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (!stall) begin
        op_valid <= s2_v;
        if (s2_v) begin
          unique case (s2_src)
            SRC_IN:   op_a <= in_q;
            SRC_HALO: op_a <= halo_q;
            default:  op_a <= '0;
          endcase
          op_b <= kern_q;
          op_first <= s2_first; op_last <= s2_last;
          op_x <= s2_x; op_y <= s2_y; op_ch <= s2_oc;
        end
        s2_v <= s1_v; s2_src <= s1_src; s2_first <= s1_first; s2_last <= s1_last;
        s2_x <= s1_x; s2_y <= s1_y; s2_oc <= s1_oc;
        s1_v       <= issue_en;
        s1_in_re   <= issue_en & (src == SRC_IN);
        s1_halo_re <= issue_en & (src == SRC_HALO);
        if (issue_en) begin
          in_addr <= ia; halo_addr <= ha; kern_addr <= ka;
          s1_src <= src;
          s1_first <= (c_ic == '0) && (c_ky == '0) && (c_kx == '0);
          s1_last <= ic_l & ky_l & kx_l;
          s1_x <= c_x; s1_y <= c_y; s1_oc <= c_oc;
          cnt_kx <= n_kx; cnt_ky <= n_ky; cnt_ic <= n_ic;
          cnt_oc <= n_oc; cnt_x <= n_x; cnt_y <= n_y;
        end
      end
      case (state)
        IDLE: if (start) begin
          if (legal) begin
            state <= RUN;
            running <= 1'b1;
            lat_in_ch <= cfg_in_ch; lat_out_ch <= cfg_out_ch;
            lat_x0 <= cfg_x0; lat_x_end <= x_end_cfg;
          end else begin
            cfg_err <= 1'b1;
          end
        end
        RUN: if (!stall && tap_last) state <= DRAIN;
        DRAIN: if (op_valid && op_ready && !s1_v && !s2_v) begin
          state <= IDLE;
          running <= 1'b0;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
